regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 160 ++++++++++++++++
 tb/tb_regfile_mp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with an issue scoreboard.
//
// After reset the block sweeps every register to zero, one per cycle. It
// then raises ready and accepts writes and busy-bit updates.
//
// Ports
//   clock            rising-edge clock for every register
//   reset            asynchronous, active-high
//   raddr[NRP*AW]    read addresses; port i uses bits [i*AW +: AW]
//   rdata[NRP*XLEN]  read data, combinational (forwarded when BYPASS=1)
//   rbusy[NRP]       scoreboard busy bit of each read address, combinational
//   wen/waddr/wdata  NWP write ports; the highest index wins on a collision
//   set_en/set_addr  marks a register busy when an instruction issues
//   ready            high once the post-reset clear sweep has finished

// One read port. It selects the stored word, then applies forwarding,
// the r0 override and the CLEAR-phase masking.
module regfile_mp_rport #(
   parameter int XLEN    = 64,
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int NWP     = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic                           run,
   input  logic [AW-1:0]                  raddr,
   input  logic [NREG-1:0][XLEN-1:0]      mem,
   input  logic [NREG-1:0]                busy,
   input  logic [NWP-1:0]                 wen,
   input  logic [NWP-1:0][AW-1:0]         waddr,
   input  logic [NWP-1:0][XLEN-1:0]       wdata,
   input  logic                           set_en,
   input  logic [AW-1:0]                  set_addr,
   output logic [XLEN-1:0]                rdata,
   output logic                           rbusy
);
   logic            hit;
   logic [XLEN-1:0] fwd;

   always_comb begin
      hit = 1'b0;
      fwd = '0;
      // The ascending loop leaves the highest-index writer in fwd.
      for (int j = 0; j < NWP; j++) begin
         if (wen[j] && waddr[j] == raddr) begin
            hit = 1'b1;
            fwd = wdata[j];
         end
      end
      rdata = mem[raddr];
      rbusy = busy[raddr];
      if (BYPASS != 0 && hit) begin
         rdata = fwd;
         // A write that lands in the same cycle as a new issue leaves the
         // register busy, so only report free when no set is pending.
         if (!(set_en && set_addr == raddr)) rbusy = 1'b0;
      end
      if (ZERO_R0 != 0 && raddr == '0) rdata = '0;
      if (!run) begin
         rdata = '0;
         rbusy = 1'b0;
      end
   end
endmodule

module regfile_mp #(
   parameter int XLEN    = 64,
   parameter int NREG    = 32,
   parameter int NRP     = 2,
   parameter int NWP     = 2,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NRP*AW-1:0]   raddr,
   output logic [NRP*XLEN-1:0] rdata,
   output logic [NRP-1:0]      rbusy,
   input  logic [NWP-1:0]      wen,
   input  logic [NWP*AW-1:0]   waddr,
   input  logic [NWP*XLEN-1:0] wdata,
   input  logic                set_en,
   input  logic [AW-1:0]       set_addr,
   output logic                ready
);
   typedef enum logic {CLEAR, RUN} state_t;

   state_t                       state;
   logic [AW-1:0]                cnt;
   logic [NREG-1:0][XLEN-1:0]    mem;
   logic [NREG-1:0]              busy;
   logic [NWP-1:0][AW-1:0]       wa;
   logic [NWP-1:0][XLEN-1:0]     wd;
   logic                         run;

   assign wa  = waddr;
   assign wd  = wdata;
   assign run = (state == RUN);

   // Control and scoreboard. The busy set is applied after the clears so
   // that a new producer wins over a retiring one on the same register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
         ready <= 1'b0;
         busy  <= '0;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(NREG - 1)) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               for (int j = 0; j < NWP; j++)
                  if (wen[j]) busy[wa[j]] <= 1'b0;
               if (set_en && !(ZERO_R0 != 0 && set_addr == '0))
                  busy[set_addr] <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Storage is not reset. The sweep zeroes it, and contents are only
   // meaningful once ready is high. Later ports overwrite earlier ones.
   always_ff @(posedge clock) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else begin
         for (int j = 0; j < NWP; j++)
            if (wen[j] && !(ZERO_R0 != 0 && wa[j] == '0))
               mem[wa[j]] <= wd[j];
      end
   end

   for (genvar i = 0; i < NRP; i++) begin : g_rd
      regfile_mp_rport #(
         .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWP(NWP),
         .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
      ) u_rp (
         .run      (run),
         .raddr    (raddr[i*AW +: AW]),
         .mem      (mem),
         .busy     (busy),
         .wen      (wen),
         .waddr    (wa),
         .wdata    (wd),
         .set_en   (set_en),
         .set_addr (set_addr),
         .rdata    (rdata[i*XLEN +: XLEN]),
         .rbusy    (rbusy[i])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- scoreboard bench for regfile_mp with default parameters.
// Each stimulus cycle pushes its expected outputs into a queue. A monitor
// pops one entry on every probed falling edge and compares it.
module tb_regfile_mp;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [9:0]   raddr = '0;
   logic [127:0] rdata;
   logic [1:0]   rbusy;
   logic [1:0]   wen = '0;
   logic [9:0]   waddr = '0;
   logic [127:0] wdata = '0;
   logic         set_en = 1'b0;
   logic [4:0]   set_addr = '0;
   logic         ready;

   typedef struct {
      string       nm;
      logic [63:0] d0, d1;
      logic        b0, b1, rdy;
   } exp_t;

   exp_t q[$];
   exp_t e;
   logic probe = 1'b0;
   int   total = 0;
   int   bad = 0;

   regfile_mp dut (
      .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata),
      .rbusy(rbusy), .wen(wen), .waddr(waddr), .wdata(wdata),
      .set_en(set_en), .set_addr(set_addr), .ready(ready)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

   // Monitor: outputs are compared mid-cycle, away from the rising edge.
   always @(negedge clock) begin
      if (probe) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL noexp: probe with empty queue, want a queued expectation");
         end else begin
            e = q.pop_front();
            if (rdata !== {e.d1, e.d0} || rbusy !== {e.b1, e.b0} || ready !== e.rdy) begin
               bad++;
               $display("FAIL %s: got rdata1=%h rdata0=%h rbusy=%b ready=%b, want %h %h %b%b %b",
                        e.nm, rdata[127:64], rdata[63:0], rbusy, ready,
                        e.d1, e.d0, e.b1, e.b0, e.rdy);
            end
         end
      end
   end

   task automatic cyc(input string nm, input logic rs,
                      input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic se, input logic [4:0] sa,
                      input logic [63:0] e0, input logic [63:0] e1,
                      input logic eb0, input logic eb1, input logic er);
      exp_t x;
      @(posedge clock);
      #1;
      reset    = rs;
      raddr    = {r1, r0};
      wen      = w;
      waddr    = {a1, a0};
      wdata    = {d1, d0};
      set_en   = se;
      set_addr = sa;
      x.nm = nm; x.d0 = e0; x.d1 = e1; x.b0 = eb0; x.b1 = eb1; x.rdy = er;
      q.push_back(x);
      probe = 1'b1;
   endtask

   task automatic idle(input string nm, input logic rs, input logic er);
      cyc(nm, rs, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h0, 64'h0, 1'b0, 1'b0, er);
   endtask

   initial begin
      // Reset state.
      idle("reset", 1'b1, 1'b0);
      idle("reset", 1'b1, 1'b0);
      // First sweep. Writes and sets are offered but must be ignored, and
      // forwarding must stay masked.
      for (int k = 0; k < 10; k++)
         cyc("sweepA", 1'b0, 5'd3, 5'd4, 2'b11, 5'd3, 5'd4, 64'h33, 64'h44,
             1'b1, 5'd3, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      // Reset arrives mid-sweep.
      idle("midrst", 1'b1, 1'b0);
      idle("midrst", 1'b1, 1'b0);
      // Fresh sweep: ready must stay low for exactly 32 cycles.
      for (int k = 0; k < 32; k++) begin
         if (k == 5)
            cyc("sweepB_wr", 1'b0, 5'd2, 5'd2, 2'b11, 5'd2, 5'd2, 64'hDEAD, 64'hBEEF,
                1'b1, 5'd2, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
         else
            idle("sweepB", 1'b0, 1'b0);
      end
      cyc("ready", 1'b0, 5'd2, 5'd31, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      cyc("rd_zero", 1'b0, 5'd1, 5'd30, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      // Dual write to the same address: port 1 wins.
      cyc("wconf_byp", 1'b0, 5'd5, 5'd5, 2'b11, 5'd5, 5'd5, 64'h55, 64'hAA, 1'b0, 5'd0,
          64'hAA, 64'hAA, 1'b0, 1'b0, 1'b1);
      cyc("wconf_st", 1'b0, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'hAA, 64'h0, 1'b0, 1'b0, 1'b1);
      // Register 0 is hardwired to zero and never becomes busy.
      cyc("r0_wr", 1'b0, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 64'h1234, 64'h0, 1'b1, 5'd0,
          64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      cyc("r0_rd", 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      // Scoreboard set, then clear by a write of register 7.
      cyc("sb_set", 1'b0, 5'd7, 5'd5, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd7,
          64'h0, 64'hAA, 1'b0, 1'b0, 1'b1);
      cyc("sb_busy", 1'b0, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h0, 64'h0, 1'b1, 1'b1, 1'b1);
      cyc("sb_wr", 1'b0, 5'd7, 5'd5, 2'b10, 5'd0, 5'd7, 64'h0, 64'h77, 1'b0, 5'd0,
          64'h77, 64'hAA, 1'b0, 1'b0, 1'b1);
      cyc("sb_after", 1'b0, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h77, 64'h77, 1'b0, 1'b0, 1'b1);
      // Set and write of register 9 in the same cycle: busy survives.
      cyc("col_same", 1'b0, 5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 64'h99, 64'h0, 1'b1, 5'd9,
          64'h99, 64'h99, 1'b0, 1'b0, 1'b1);
      cyc("col_after", 1'b0, 5'd9, 5'd7, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h99, 64'h77, 1'b1, 1'b0, 1'b1);
      // A plain write of 9 retires it.
      cyc("col_clr", 1'b0, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 64'h0, 64'h9A, 1'b0, 5'd0,
          64'h9A, 64'h0, 1'b0, 1'b0, 1'b1);
      cyc("col_free", 1'b0, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h9A, 64'h9A, 1'b0, 1'b0, 1'b1);
      // Two distinct writes, read crosswise, then read back from storage.
      cyc("dual_byp", 1'b0, 5'd11, 5'd10, 2'b11, 5'd10, 5'd11, 64'h1010, 64'h1111,
          1'b0, 5'd0, 64'h1111, 64'h1010, 1'b0, 1'b0, 1'b1);
      cyc("dual_st", 1'b0, 5'd10, 5'd11, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0,
          64'h1010, 64'h1111, 1'b0, 1'b0, 1'b1);
      @(posedge clock);
      probe = 1'b0;
      #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
